mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//  Shares the single-port data memory (word array, comb read, sync write, byte-store/byte-load
//  support) between two requesters: the MEM stage (data port D) and instruction fetch (port I).
//  Sequences each access as a fixed multi-cycle memory transaction, returns read data and a
//  completion pulse, and prevents starvation of port I under fixed D-priority.
// PARAMETERS
//  XLEN         32  data width
//  ADDR_SIZE    5   memory word-address width
//  LATENCY      2   cycles memory command is held per access (>=1)
//  STARVE_LIMIT 3   consecutive contested losses of I before I is forced a grant (0 = pure D priority)
// PORTS
//  clk        in   1          clock
//  rst        in   1          reset, asynchronous, active-high
//  d_req      in   1          D request; held with d_* fields stable until d_gnt
//  d_we       in   1          D store (1) / load (0)
//  d_byt      in   1          D byte access (low 8 bits, zero-extended on load)
//  d_addr     in   ADDR_SIZE  D word address
//  d_wdata    in   XLEN       D store data
//  d_gnt      out  1          D request accepted this cycle (combinational)
//  d_rvalid   out  1          1-cycle D completion pulse (loads and stores)
//  d_rdata    out  XLEN       D load data, valid with d_rvalid
//  i_req      in   1          I request (always word read)
//  i_addr     in   ADDR_SIZE  I word address
//  i_gnt      out  1          I request accepted this cycle (combinational)
//  i_rvalid   out  1          1-cycle I completion pulse
//  i_rdata    out  XLEN       I read data, valid with i_rvalid
//  m_en       out  1          memory command active
//  m_we       out  1          memory write strobe
//  m_byt      out  1          memory byte mode
//  m_addr     out  ADDR_SIZE  memory address
//  m_wdata    out  XLEN       memory write data
//  m_rdata    in   XLEN       memory read data (comb from m_addr, m_byt)
//  busy       out  1          transaction in flight (state != IDLE)
// BEHAVIOUR
//  - One clock; reset is asynchronous and active-high (clk, rst).
//  - Reset: state IDLE; all outputs 0 (gnt forced 0 while rst); starve counter 0; latched op cleared.
//  - FSM: IDLE -> BUSY on acceptance; BUSY holds LATENCY cycles (down-counter) -> IDLE.
//  - Acceptance only in IDLE; gnt = IDLE & req & arbitration win; op (port, we, byt, addr, wdata)
//    latched at that edge.
//  - Arbitration: only one req -> it wins. Both -> D wins unless starve_cnt == STARVE_LIMIT
//    and STARVE_LIMIT != 0, then I wins.
//  - starve_cnt: +1 on each edge where I lost a contested arbitration (saturating at STARVE_LIMIT);
//    cleared on I grant or whenever i_req == 0.
//  - BUSY: m_en=1, m_addr/m_byt/m_wdata from latched op, stable for all LATENCY cycles;
//    m_we=1 only in last BUSY cycle of a store (exactly one write edge per store).
//  - Last BUSY cycle: m_rdata captured into d_rdata or i_rdata register (loads only; store
//    leaves rdata unchanged).
//  - Cycle after last BUSY (state IDLE): owning rvalid = 1 for one cycle; a new request may be
//    granted in that same cycle -> throughput one access per LATENCY+1 cycles.
//  - Latency: gnt at cycle t -> rvalid at cycle t+LATENCY+1.
//  - I port never writes: m_we=0, m_byt=0 for I transactions.
//  - rdata registers hold value until next load completion on that port.
//  - rst mid-BUSY: transaction dropped, no write occurs (m_we falls asynchronously),
//    no rvalid; requester must re-request.
//  - req deasserted while not granted: no effect, no state change.
// TESTING (LATENCY=2, STARVE_LIMIT=2 unless stated)
//  1 D store w addr5=0xDEADBEEF at c0 -> d_gnt c0, m_en c1-c2, m_we c2 only, d_rvalid c3;
//    D load addr5 -> d_rdata=0xDEADBEEF with d_rvalid
//  2 D byte store 0x12345678 to addr3, D word load addr3 -> d_rdata=0x00000078
//  3 d_req and i_req held high -> grant order D,D,I,D,D,I; starve_cnt 0,1,2,0; i_rvalid after
//    each I grant +3
//  4 i_req only, addr5 (holding 0xDEADBEEF) -> i_gnt c0, i_rvalid c3, i_rdata=0xDEADBEEF, m_we=0
//  5 rst pulsed in c2 of pending store addr7=0xAAAA5555 -> m_we never 1, no d_rvalid,
//    all outputs 0, addr7 unchanged
//  6 back-to-back D loads: 2nd d_req granted in 1st d_rvalid cycle -> rvalid pulses 3 cycles
//    apart; STARVE_LIMIT=0 with both req -> I never granted

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signal bundle for mem_arbiter.
// The slave modport is the arbiter's view; master is the requesters plus memory.
interface mem_arbiter_if #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned ADDR_SIZE = 5
);
    logic                 d_req;
    logic                 d_we;
    logic                 d_byt;
    logic [ADDR_SIZE-1:0] d_addr;
    logic [XLEN-1:0]      d_wdata;
    logic                 d_gnt;
    logic                 d_rvalid;
    logic [XLEN-1:0]      d_rdata;

    logic                 i_req;
    logic [ADDR_SIZE-1:0] i_addr;
    logic                 i_gnt;
    logic                 i_rvalid;
    logic [XLEN-1:0]      i_rdata;

    logic                 m_en;
    logic                 m_we;
    logic                 m_byt;
    logic [ADDR_SIZE-1:0] m_addr;
    logic [XLEN-1:0]      m_wdata;
    logic [XLEN-1:0]      m_rdata;

    modport slave (
        input  d_req, d_we, d_byt, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
        input  i_req, i_addr,
        output i_gnt, i_rvalid, i_rdata,
        output m_en, m_we, m_byt, m_addr, m_wdata,
        input  m_rdata
    );

    modport master (
        output d_req, d_we, d_byt, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
        output i_req, i_addr,
        input  i_gnt, i_rvalid, i_rdata,
        input  m_en, m_we, m_byt, m_addr, m_wdata,
        output m_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares a single-port data memory between the MEM-stage port (D) and fetch (I).
// D has fixed priority; I is forced through after STARVE_LIMIT contested losses.
module mem_arbiter #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned ADDR_SIZE    = 5,
    parameter int unsigned LATENCY      = 2,
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus,
    output logic          busy
);
    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int unsigned STV_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state;
    logic [CNT_W-1:0] lat_cnt;
    logic [STV_W-1:0] starve_cnt;
    logic             op_i;
    logic             op_we;

    logic contested;
    logic i_forced;
    logic i_win;
    logic d_win;
    logic d_gnt_c;
    logic i_gnt_c;

    // Arbitration; grants are only offered while idle and out of reset
    always_comb begin
        contested = bus.d_req && bus.i_req;
        i_forced  = (STARVE_LIMIT != 0) && (starve_cnt == STV_W'(STARVE_LIMIT));
        i_win     = bus.i_req && (!bus.d_req || i_forced);
        d_win     = bus.d_req && !i_win;
        d_gnt_c   = !rst && (state == IDLE) && d_win;
        i_gnt_c   = !rst && (state == IDLE) && i_win;
    end

    assign bus.d_gnt = d_gnt_c;
    assign bus.i_gnt = i_gnt_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            lat_cnt     <= '0;
            starve_cnt  <= '0;
            op_i        <= 1'b0;
            op_we       <= 1'b0;
            busy        <= 1'b0;
            bus.m_en    <= 1'b0;
            bus.m_we    <= 1'b0;
            bus.m_byt   <= 1'b0;
            bus.m_addr  <= '0;
            bus.m_wdata <= '0;
            bus.d_rvalid <= 1'b0;
            bus.i_rvalid <= 1'b0;
            bus.d_rdata <= '0;
            bus.i_rdata <= '0;
        end else begin
            bus.d_rvalid <= 1'b0;
            bus.i_rvalid <= 1'b0;

            // Count only arbitrations I actually lost; any gap in i_req forgives it
            if (!bus.i_req || i_gnt_c) begin
                starve_cnt <= '0;
            end else if (d_gnt_c && contested && (starve_cnt != STV_W'(STARVE_LIMIT))) begin
                starve_cnt <= starve_cnt + STV_W'(1);
            end

            case (state)
                IDLE: begin
                    if (d_gnt_c || i_gnt_c) begin
                        state       <= BUSY;
                        busy        <= 1'b1;
                        lat_cnt     <= CNT_W'(LATENCY - 1);
                        op_i        <= i_gnt_c;
                        op_we       <= d_gnt_c && bus.d_we;
                        bus.m_en    <= 1'b1;
                        bus.m_we    <= (LATENCY == 1) && d_gnt_c && bus.d_we;
                        bus.m_byt   <= d_gnt_c && bus.d_byt;
                        bus.m_addr  <= d_gnt_c ? bus.d_addr : bus.i_addr;
                        bus.m_wdata <= d_gnt_c ? bus.d_wdata : '0;
                    end
                end
                BUSY: begin
                    if (lat_cnt == '0) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        bus.m_en <= 1'b0;
                        bus.m_we <= 1'b0;
                        if (op_i) begin
                            bus.i_rvalid <= 1'b1;
                            bus.i_rdata  <= bus.m_rdata;
                        end else begin
                            bus.d_rvalid <= 1'b1;
                            if (!op_we) begin
                                bus.d_rdata <= bus.m_rdata;
                            end
                        end
                    end else begin
                        // Write strobe lands on the final command cycle only
                        lat_cnt  <= lat_cnt - CNT_W'(1);
                        bus.m_we <= op_we && (lat_cnt == CNT_W'(1));
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
